// File: rtl/reg_share_arb_pkg.sv
// rtl/reg_share_arb_pkg.sv - shared types and helpers for the shared-register arbiter
package reg_share_arb_pkg;

  // 2'd3 is not a named state; the FSM recovers from it to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  // Index width that stays at least one bit wide when there is a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_share_arb_if.sv
// rtl/reg_share_arb_if.sv - requester-side bus of the shared-register arbiter
interface reg_share_arb_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]       req;
  logic [N-1:0]       wr;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       gnt;
  logic [N-1:0]       ack;
  logic [WIDTH-1:0]   rdata;
  logic [WIDTH-1:0]   q;
  logic               busy;

  modport master (output req, wr, wdata, input gnt, ack, rdata, q, busy);
  modport slave  (input req, wr, wdata, output gnt, ack, rdata, q, busy);
endinterface

// File: rtl/reg_share_arb_rr_pick.sv
// rtl/reg_share_arb_rr_pick.sv - combinational round-robin priority picker
// Searches req upward from ptr, wrapping N-1 to 0; the first asserted bit wins.
module rr_pick
  import reg_share_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  // One extra bit so ptr + k can exceed N-1 before the wrap subtraction.
  logic [IW:0] pos;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!any && req[pos[IW-1:0]]) begin
        any                = 1'b1;
        win[pos[IW-1:0]]   = 1'b1;
        win_idx            = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin sharing of one storage register among N requesters
// Each grant is one read or write access lasting three cycles: IDLE, GRANT, ACK.
module reg_share_arb
  import reg_share_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           clr,
  reg_share_arb_if.slave bus
);

  localparam int IW = idx_w(N);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    w;
  logic [N-1:0]     gnt_r;
  logic [N-1:0]     ack_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rdata_r;

  logic [N-1:0]     win;
  logic [IW-1:0]    win_idx;
  logic             any;

  rr_pick #(.N(N)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_IDLE;
      ptr     <= '0;
      w       <= '0;
      gnt_r   <= '0;
      ack_r   <= '0;
      q_r     <= '0;
      rdata_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any) begin
            w     <= win_idx;
            gnt_r <= win;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // wr/wdata are only looked at here, so a requester may drop req after grant.
          if (bus.wr[w]) begin
            q_r <= bus.wdata[int'(w)*WIDTH +: WIDTH];
          end else begin
            rdata_r <= q_r;
          end
          ack_r <= gnt_r;
          state <= S_ACK;
        end
        S_ACK: begin
          ptr   <= (int'(w) == N-1) ? '0 : w + 1'b1;
          gnt_r <= '0;
          ack_r <= '0;
          state <= S_IDLE;
        end
        default: begin
          gnt_r <= '0;
          ack_r <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.ack   = ack_r;
  assign bus.q     = q_r;
  assign bus.rdata = rdata_r;
  assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_reg_share_arb.sv
// tb/tb_reg_share_arb.sv - randomized self-checking bench for reg_share_arb
module tb_reg_share_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  reg_share_arb_if #(.N(N), .WIDTH(W)) bus ();

  reg_share_arb #(.N(N), .WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending requests plus the register contents and rotation pointer.
  bit   [N-1:0] pend;
  bit   [N-1:0] m_wr;
  logic [W-1:0] m_wd [N];
  logic [W-1:0] m_q;
  logic [W-1:0] m_rdata;
  int           m_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit is_wr, input logic [W-1:0] d);
    bus.req[i]           = 1'b1;
    bus.wr[i]            = is_wr;
    bus.wdata[i*W +: W]  = d;
    pend[i]              = 1'b1;
    m_wr[i]              = is_wr;
    m_wd[i]              = d;
  endtask

  task automatic arrivals();
    for (int j = 0; j < N; j++) begin
      if (!pend[j] && $urandom_range(0, 3) == 0) begin
        set_req(j, 1'($urandom_range(0, 1)), W'($urandom));
      end
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    pend    = '0;
    m_q     = '0;
    m_rdata = '0;
    m_ptr   = 0;
    bus.req = '0;
  endtask

  // One complete access, entered and left at a negedge while the DUT is idle.
  task automatic do_access(input bit drop, input bit keep, input bit rnd, output int w);
    logic [N-1:0] oh;
    w      = pick();
    oh     = '0;
    oh[w]  = 1'b1;
    tick();
    check("gnt_grant", bus.gnt, oh);
    check("ack_grant", bus.ack, 0);
    check("busy_grant", bus.busy, 1);
    if (drop || (rnd && $urandom_range(0, 3) == 0)) bus.req[w] = 1'b0;
    if (rnd) arrivals();
    tick();
    if (m_wr[w]) m_q = m_wd[w];
    else         m_rdata = m_q;
    check("ack_ack", bus.ack, oh);
    check("gnt_ack", bus.gnt, oh);
    check("q_ack", bus.q, m_q);
    check("rdata_ack", bus.rdata, m_rdata);
    check("busy_ack", bus.busy, 1);
    if (!keep) begin
      pend[w]    = 1'b0;
      bus.req[w] = 1'b0;
    end
    if (rnd) arrivals();
    tick();
    m_ptr = (w + 1) % N;
    check("gnt_idle", bus.gnt, 0);
    check("ack_idle", bus.ack, 0);
    check("busy_idle", bus.busy, 0);
  endtask

  initial begin
    int w;
    clr       = 1'b1;
    bus.req   = '1;
    bus.wr    = '1;
    bus.wdata = '1;
    pend      = '0;
    m_wr      = '0;
    for (int i = 0; i < N; i++) m_wd[i] = '0;
    @(negedge clk);

    // Reset held for two edges with every requester asking.
    repeat (2) begin
      tick();
      check("rst_gnt", bus.gnt, 0);
      check("rst_ack", bus.ack, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_q", bus.q, 0);
      check("rst_rdata", bus.rdata, 0);
    end
    clr       = 1'b0;
    bus.wr    = '0;
    bus.wdata = '0;
    model_reset();

    set_req(1, 1'b1, 8'hA5);
    do_access(1'b0, 1'b0, 1'b0, w);
    check("wr_idx", w, 1);
    check("wr_q", bus.q, 8'hA5);

    set_req(3, 1'b0, 8'h00);
    do_access(1'b0, 1'b0, 1'b0, w);
    check("rd_idx", w, 3);
    check("rd_rdata", bus.rdata, 8'hA5);
    check("rd_q", bus.q, 8'hA5);

    for (int i = 0; i < N; i++) set_req(i, 1'b1, W'(i + 1));
    for (int k = 0; k < 5; k++) begin
      do_access(1'b0, k < 4, 1'b0, w);
      check("fair_order", w, k % N);
      check("fair_q", bus.q, (k % N) + 1);
    end
    pend    = '0;
    bus.req = '0;

    set_req(2, 1'b1, 8'h3C);
    do_access(1'b1, 1'b0, 1'b0, w);
    check("wd_idx", w, 2);
    check("wd_q", bus.q, 8'h3C);

    // Reset lands on the edge that would have completed a write of 8'hFF.
    set_req(1, 1'b1, 8'hFF);
    tick();
    check("mr_gnt", bus.gnt, 4'b0010);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_reset();
    check("mr_ack", bus.ack, 0);
    check("mr_gnt0", bus.gnt, 0);
    check("mr_q", bus.q, 0);
    check("mr_busy", bus.busy, 0);
    tick();
    check("mr_ack2", bus.ack, 0);
    check("mr_q2", bus.q, 0);
    set_req(2, 1'b0, 8'h00);
    set_req(0, 1'b0, 8'h00);
    do_access(1'b0, 1'b0, 1'b0, w);
    check("mr_next", w, 0);
    check("mr_rdata", bus.rdata, 0);

    repeat (400) begin
      if (pend == '0) arrivals();
      if (pend == '0) begin
        tick();
        check("rnd_idle_gnt", bus.gnt, 0);
        check("rnd_idle_busy", bus.busy, 0);
      end else begin
        do_access(1'b0, 1'b0, 1'b1, w);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
